// File: rtl/pps_pkg.sv
// Shared definitions for the PPS period checker: FSM encoding, monitoring status bit
// positions and the nominal/limit interval arithmetic.
package pps_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 25;

  typedef enum logic {
    StWaitFirst = 1'b0,
    StRun       = 1'b1
  } pps_state_e;

  // Bit positions used when the status outputs are packed into a monitoring word.
  localparam int unsigned StatusOkBit     = 0;
  localparam int unsigned StatusLostBit   = 1;
  localparam int unsigned StatusLockedBit = 2;
  localparam int unsigned StatusValidBit  = 3;
  localparam int unsigned StatusWidth     = 4;

  function automatic logic [31:0] calc_nominal(input int unsigned period_us,
                                               input int unsigned clk_mhz);
    return 32'(period_us * clk_mhz);
  endfunction

  function automatic logic [31:0] calc_limit(input logic [31:0] nominal,
                                             input int unsigned tol);
    return nominal + 32'(tol);
  endfunction

  // Lower tolerance bound, clamped at zero when the tolerance exceeds the nominal.
  function automatic logic [31:0] calc_low(input logic [31:0] nominal,
                                           input int unsigned tol);
    return (nominal >= 32'(tol)) ? nominal - 32'(tol) : 32'd0;
  endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// PPS input conditioning: optional 2-flop synchronizer (macro PPS_SYNC_EN) followed by a
// rising-edge detector producing a one-cycle strobe.
module pps_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pps_i,
  output logic edge_o
);

  logic pps_s;
  logic prev_q, prev_d;

`ifdef PPS_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], pps_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pps_s = sync_q[1];
`else
  assign pps_s = pps_i;
`endif

  always_comb begin
    prev_d = pps_s;
  end

  // Resets to sampled-low so an input already high at reset release gives one edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign edge_o = pps_s & ~prev_q;

endmodule

// File: rtl/pps_period_checker.sv
// Measures cycles between PPS rising edges, flags tolerance, loss and lock.
// Build option: define PPS_SYNC_EN to synchronize an asynchronous i_pps.
module pps_period_checker
  import pps_pkg::*;
#(
  parameter int unsigned PERIOD     = 1000000,
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int unsigned TOL        = 25,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        i_clk_25MHz,
  input  logic        i_rst,
  input  logic        i_pps,
  output logic [31:0] o_period,
  output logic        o_valid,
  output logic        o_ok,
  output logic        o_lost,
  output logic        o_locked
);

  localparam logic [31:0] NOMINAL     = calc_nominal(PERIOD, CLK_FREQ);
  localparam logic [31:0] LIMIT       = calc_limit(NOMINAL, TOL);
  localparam logic [31:0] LOW_BOUND   = calc_low(NOMINAL, TOL);
  localparam logic [3:0]  LOCK_TARGET = 4'(LOCK_COUNT);

  if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock_count
    $error("LOCK_COUNT must be in 1..15");
  end

  logic        pps_edge;
  logic        in_tol;
  logic [3:0]  good_inc;

  pps_state_e  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        ok_q, ok_d;
  logic        lost_q, lost_d;
  logic        locked_q, locked_d;
  logic [3:0]  good_q, good_d;

  pps_edge_sync u_edge_sync (
    .clk_i  (i_clk_25MHz),
    .rst_i  (i_rst),
    .pps_i  (i_pps),
    .edge_o (pps_edge)
  );

  assign in_tol   = (count_q >= LOW_BOUND) && (count_q <= LIMIT);
  assign good_inc = (good_q >= LOCK_TARGET) ? good_q : good_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    valid_d  = 1'b0;
    ok_d     = ok_q;
    lost_d   = lost_q;
    locked_d = locked_q;
    good_d   = good_q;

    unique case (state_q)
      StWaitFirst: begin
        if (pps_edge) begin
          state_d = StRun;
          count_d = 32'd1;
          lost_d  = 1'b0;
        end
      end

      StRun: begin
        // An edge on the same cycle the count reaches LIMIT is still a valid interval.
        if (pps_edge) begin
          period_d = count_q;
          valid_d  = 1'b1;
          ok_d     = in_tol;
          count_d  = 32'd1;
          lost_d   = 1'b0;
          if (in_tol) begin
            good_d   = good_inc;
            locked_d = (good_inc >= LOCK_TARGET);
          end else begin
            good_d   = 4'd0;
            locked_d = 1'b0;
          end
        end else if (count_q >= LIMIT) begin
          state_d  = StWaitFirst;
          count_d  = 32'd0;
          lost_d   = 1'b1;
          locked_d = 1'b0;
          good_d   = 4'd0;
        end else begin
          count_d = count_q + 32'd1;
        end
      end

      default: begin
        state_d = StWaitFirst;
        count_d = 32'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk_25MHz or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StWaitFirst;
      count_q  <= 32'd0;
      period_q <= 32'd0;
      valid_q  <= 1'b0;
      ok_q     <= 1'b0;
      lost_q   <= 1'b0;
      locked_q <= 1'b0;
      good_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ok_q     <= ok_d;
      lost_q   <= lost_d;
      locked_q <= locked_d;
      good_q   <= good_d;
    end
  end

  assign o_period = period_q;
  assign o_valid  = valid_q;
  assign o_ok     = ok_q;
  assign o_lost   = lost_q;
  assign o_locked = locked_q;

endmodule

// File: tb/tb_pps_period_checker.sv
// Directed bench for pps_period_checker: NOMINAL=100, TOL=2, LIMIT=102, LOCK_COUNT=3.
module tb_pps_period_checker;

  logic        clk;
  logic        rst;
  logic        pps;
  logic [31:0] o_period;
  logic        o_valid;
  logic        o_ok;
  logic        o_lost;
  logic        o_locked;

  int checks;
  int failures;
  int stray_valid;

  logic [31:0] cap_period;
  logic        cap_valid;
  logic        cap_ok;
  logic        cap_lost;
  logic        cap_locked;

  pps_period_checker #(
    .PERIOD     (4),
    .CLK_FREQ   (25),
    .TOL        (2),
    .LOCK_COUNT (3)
  ) dut (
    .i_clk_25MHz (clk),
    .i_rst       (rst),
    .i_pps       (pps),
    .o_period    (o_period),
    .o_valid     (o_valid),
    .o_ok        (o_ok),
    .o_lost      (o_lost),
    .o_locked    (o_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Edge sampled on the first posedge; next call's edge lands exactly gap cycles later.
  task automatic pulse(input int width, input int gap);
    pps = 1'b1;
    cyc();
    cap_valid  = o_valid;
    cap_period = o_period;
    cap_ok     = o_ok;
    cap_lost   = o_lost;
    cap_locked = o_locked;
    for (int j = 1; j < gap; j++) begin
      pps = (j < width);
      cyc();
      if (o_valid) stray_valid++;
    end
    pps = 1'b0;
  endtask

  task automatic check_edge(input string name, input logic exp_valid, input logic [31:0] exp_period,
                            input logic exp_ok, input logic exp_locked);
    checks++;
    if ({cap_valid, cap_period, cap_ok, cap_locked, cap_lost} !==
        {exp_valid, exp_period, exp_ok, exp_locked, 1'b0}) begin
      failures++;
      $display("FAIL %s actual valid=%b period=%0d ok=%b locked=%b lost=%b required valid=%b period=%0d ok=%b locked=%b lost=0",
               name, cap_valid, cap_period, cap_ok, cap_locked, cap_lost,
               exp_valid, exp_period, exp_ok, exp_locked);
    end
  endtask

  task automatic check_stray(input string name);
    checks++;
    if (stray_valid !== 0) begin
      failures++;
      $display("FAIL %s stray o_valid actual=%0d required=0", name, stray_valid);
    end
    stray_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pps = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({o_valid, o_period, o_ok, o_lost, o_locked} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=0",
               {o_valid, o_period, o_ok, o_lost, o_locked});
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_lock();
    pulse(1, 100);
    check_edge("t1_first_edge", 1'b0, 32'd0, 1'b0, 1'b0);
    pulse(1, 100);
    check_edge("t1_edge2", 1'b1, 32'd100, 1'b1, 1'b0);
    pulse(1, 100);
    check_edge("t1_edge3", 1'b1, 32'd100, 1'b1, 1'b0);
    pulse(1, 97);
    check_edge("t1_edge4_lock", 1'b1, 32'd100, 1'b1, 1'b1);
    check_stray("t1_stray");
  endtask

  task automatic test_bad_interval();
    pulse(1, 100);
    check_edge("t2_short97", 1'b1, 32'd97, 1'b0, 1'b0);
    pulse(1, 100);
    check_edge("t2_relock1", 1'b1, 32'd100, 1'b1, 1'b0);
    pulse(1, 100);
    check_edge("t2_relock2", 1'b1, 32'd100, 1'b1, 1'b0);
    pulse(1, 98);
    check_edge("t2_relock3", 1'b1, 32'd100, 1'b1, 1'b1);
    check_stray("t2_stray");
  endtask

  task automatic test_boundaries_and_loss();
    pulse(1, 102);
    check_edge("t3_low98", 1'b1, 32'd98, 1'b1, 1'b1);
    pulse(1, 101);
    check_edge("t3_high102", 1'b1, 32'd102, 1'b1, 1'b1);
    pps = 1'b0;
    cyc();
    checks++;
    if ({o_lost, o_locked, o_valid} !== 3'b010) begin
      failures++;
      $display("FAIL t3_count101 actual lost/locked/valid=%b required=010",
               {o_lost, o_locked, o_valid});
    end
    cyc();
    checks++;
    if ({o_lost, o_locked, o_valid} !== 3'b100) begin
      failures++;
      $display("FAIL t3_timeout actual lost/locked/valid=%b required=100",
               {o_lost, o_locked, o_valid});
    end
    check_stray("t3_stray");
  endtask

  task automatic test_recover();
    pulse(1, 100);
    check_edge("t4_rearm", 1'b0, 32'd102, 1'b1, 1'b0);
    pulse(1, 100);
    check_edge("t4_first_after_loss", 1'b1, 32'd100, 1'b1, 1'b0);
    check_stray("t4_stray");
  endtask

  task automatic test_wide_pulse();
    pulse(50, 100);
    check_edge("t5_wide1", 1'b1, 32'd100, 1'b1, 1'b0);
    pulse(50, 100);
    check_edge("t5_wide2_lock", 1'b1, 32'd100, 1'b1, 1'b1);
    pulse(50, 60);
    check_edge("t5_wide3", 1'b1, 32'd100, 1'b1, 1'b1);
    check_stray("t5_stray");
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({o_valid, o_period, o_ok, o_lost, o_locked} !== 36'd0) begin
      failures++;
      $display("FAIL t6_async_reset actual=%h required=0",
               {o_valid, o_period, o_ok, o_lost, o_locked});
    end
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    pulse(1, 100);
    check_edge("t6_rearm", 1'b0, 32'd0, 1'b0, 1'b0);
    pulse(1, 100);
    check_edge("t6_measure", 1'b1, 32'd100, 1'b1, 1'b0);
    check_stray("t6_stray");
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    stray_valid = 0;
    rst         = 1'b1;
    pps         = 1'b0;
    test_reset();
    test_lock();
    test_bad_interval();
    test_boundaries_and_loss();
    test_recover();
    test_wide_pulse();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
